rmw_sequencer: RTL and testbench
================================

RMW_SEQUENCER -- requirements
Module: rmw_sequencer

Interface
REQ-001 clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 instr_valid  input  1  opcode and operand bytes are valid this cycle.
REQ-004 instr_opcode  input  8  6502 opcode.
REQ-005 instr_lo, instr_hi  input  8 each  operand address low and high bytes.
REQ-006 instr_ready  output  1  sequencer can accept an instruction.
REQ-007 alu_op  output  3  operation code sent to the alu block, using the encodings in inc/alu_ops.vh.
REQ-008 alu_a, alu_b  output  8 each  alu operands.
REQ-009 alu_result  input  8  combinational result returned by the alu block.
REQ-010 mem_addr  output  16  memory address.
REQ-011 mem_re, mem_we  output  1 each  read and write strobes; read data arrives one cycle after mem_re.
REQ-012 mem_wdata  output  8  write data.
REQ-013 mem_rdata  input  8  read data.
REQ-014 acc  output  8  accumulator.
REQ-015 flag_c, flag_z, flag_n  output  1 each  carry, zero and negative flags.
REQ-016 done  output  1  one-cycle pulse when an instruction retires.
REQ-017 illegal  output  1  qualifies done when the opcode was unsupported.

Function
REQ-018 States: IDLE, EXEC, READ, WAIT, MODIFY, WRITE, DONE; instr_ready SHALL be 1 only in IDLE.
REQ-019 Handshake: an instruction SHALL be accepted in cycle T when instr_valid and instr_ready are both 1; the opcode and operands SHALL be latched at the end of T; inputs in all other cycles SHALL be ignored.
REQ-020 Opcodes: 0x0A = ASL A; 0x06 = ASL zp (address {8'h00, lo}); 0x0E = ASL abs (address {hi, lo}); any other opcode is illegal.
REQ-021 ASL A: T+1 EXEC drives alu_op=ASL and alu_a=acc; at the end of T+1, acc<=alu_result, flag_c<=old acc[7], flag_z<=(alu_result==0), flag_n<=alu_result[7]; T+2 DONE.
REQ-022 Memory ASL: T+1 READ drives mem_re=1 and mem_addr; T+2 WAIT latches mem_rdata into tmp at the end of the cycle; T+3 MODIFY drives alu_op=ASL and alu_a=tmp, then latches the result and updates the flags from tmp and the result; T+4 WRITE drives mem_we=1, the same mem_addr, and mem_wdata=result; T+5 DONE. acc SHALL be unchanged.
REQ-023 Illegal opcode: T+1 DONE with illegal=1; acc, flags and memory SHALL be untouched.
REQ-024 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE; the earliest next acceptance is the cycle after DONE.
REQ-025 Outside EXEC and MODIFY, alu_op SHALL be NOP (new constant in inc/alu_ops.vh); alu_b SHALL always be 0.
REQ-026 mem_re and mem_we SHALL never both be high, and each SHALL be high for exactly one cycle per memory instruction.
REQ-027 Address arithmetic SHALL form 16 bits by concatenation only, with no carry; zero-page lo=0xFF SHALL give address 0x00FF.
REQ-028 mem_addr and mem_wdata SHALL be 0 when the corresponding strobe is low.

Reset
REQ-029 When rst is sampled high, the next state SHALL be IDLE and acc, tmp, all flags, done, illegal, mem_re and mem_we SHALL be 0; alu_op SHALL be NOP.
REQ-030 Reset in any state, including WRITE, SHALL abandon the instruction with no done pulse; a write SHALL occur only if rst was low in that WRITE cycle.
REQ-031 rst SHALL take priority over a simultaneous instr_valid.

Structure
REQ-032 ALU op encodings (ASL, NOP) SHALL live in the shared inc/alu_ops.vh; opcode and state encodings SHALL be localparams of this block.
REQ-033 The block SHALL contain no sub-modules; the alu block SHALL be instantiated beside it at the next level up.

Verification
REQ-034 Reset, then ASL A with acc preset to 0x81 -> acc=0x02, C=1, Z=0, N=0, done at T+2.
REQ-035 ASL zp with lo=0x10 and mem[0x0010]=0x40 -> mem_re at T+1, mem_we at T+4 with addr 0x0010 and wdata 0x80, N=1, C=0, done at T+5.
REQ-036 ASL abs with hi=0x12, lo=0x34 and mem=0x80 -> write 0x00 to 0x1234, Z=1, C=1.
REQ-037 Opcode 0xEA -> done and illegal at T+1, no memory strobes, acc and flags unchanged.
REQ-038 rst asserted during WAIT of an ASL zp -> no mem_we, no done, IDLE next cycle; instr_valid held high during busy states -> no second acceptance until IDLE.

Source files
------------

// File: rtl/rmw_sequencer_pkg.sv
// Shared ALU operation encodings used by rmw_sequencer and the neighbouring alu block.
package rmw_sequencer_pkg;

    localparam logic [2:0] ALU_NOP = 3'd0;
    localparam logic [2:0] ALU_ASL = 3'd1;

endpackage

// File: rtl/rmw_sequencer.sv
// Read-modify-write sequencer for the 6502 ASL family (accumulator, zero page, absolute).
// The ALU lives outside; this block only steers operands and latches its combinational result.
module rmw_sequencer
    import rmw_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [7:0]  instr_opcode,
    input  logic [7:0]  instr_lo,
    input  logic [7:0]  instr_hi,
    output logic        instr_ready,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_result,
    output logic [15:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  acc,
    output logic        flag_c,
    output logic        flag_z,
    output logic        flag_n,
    output logic        done,
    output logic        illegal
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_EXEC   = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_MODIFY = 3'd4;
    localparam logic [2:0] S_WRITE  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [7:0] OP_ASL_A   = 8'h0A;
    localparam logic [7:0] OP_ASL_ZP  = 8'h06;
    localparam logic [7:0] OP_ASL_ABS = 8'h0E;

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [15:0] addr;
    logic [7:0]  tmp;
    logic [7:0]  res;
    logic        ill;
    logic        accept;

    assign accept = (state == S_IDLE) && instr_valid;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (instr_valid) begin
                    case (instr_opcode)
                        OP_ASL_A:               state_nx = S_EXEC;
                        OP_ASL_ZP, OP_ASL_ABS:  state_nx = S_READ;
                        default:                state_nx = S_DONE;
                    endcase
                end
            end
            S_EXEC:   state_nx = S_DONE;
            S_READ:   state_nx = S_WAIT;
            S_WAIT:   state_nx = S_MODIFY;
            S_MODIFY: state_nx = S_WRITE;
            S_WRITE:  state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            addr   <= 16'h0000;
            tmp    <= 8'h00;
            res    <= 8'h00;
            ill    <= 1'b0;
            acc    <= 8'h00;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                // Plain concatenation: a zero-page operand never carries into the high byte.
                addr <= (instr_opcode == OP_ASL_ZP) ? {8'h00, instr_lo} : {instr_hi, instr_lo};
                ill  <= !((instr_opcode == OP_ASL_A) || (instr_opcode == OP_ASL_ZP) ||
                          (instr_opcode == OP_ASL_ABS));
            end
            case (state)
                S_EXEC: begin
                    acc    <= alu_result;
                    flag_c <= acc[7];
                    flag_z <= (alu_result == 8'h00);
                    flag_n <= alu_result[7];
                end
                S_WAIT: tmp <= mem_rdata;
                S_MODIFY: begin
                    res    <= alu_result;
                    flag_c <= tmp[7];
                    flag_z <= (alu_result == 8'h00);
                    flag_n <= alu_result[7];
                end
                default: ;
            endcase
        end
    end

    // Strobes are gated by rst so a reset landing in WRITE or DONE suppresses the write and the pulse.
    assign instr_ready = (state == S_IDLE);
    assign done        = (state == S_DONE) && !rst;
    assign illegal     = done && ill;
    assign mem_re      = (state == S_READ) && !rst;
    assign mem_we      = (state == S_WRITE) && !rst;
    assign mem_addr    = (mem_re || mem_we) ? addr : 16'h0000;
    assign mem_wdata   = mem_we ? res : 8'h00;
    assign alu_op      = (!rst && ((state == S_EXEC) || (state == S_MODIFY))) ? ALU_ASL : ALU_NOP;
    assign alu_a       = (state == S_EXEC) ? acc : ((state == S_MODIFY) ? tmp : 8'h00);
    assign alu_b       = 8'h00;

endmodule

// File: tb/tb_rmw_sequencer.sv
// Directed bench for rmw_sequencer: a vector table of instructions plus reset/handshake corner cases.
module tb_rmw_sequencer;
    import rmw_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [7:0]  instr_opcode, instr_lo, instr_hi;
    logic        instr_ready;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a, alu_b, alu_result;
    logic [15:0] mem_addr;
    logic        mem_re, mem_we;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [7:0]  acc;
    logic        flag_c, flag_z, flag_n, done, illegal;

    always #5 clk = ~clk;

    rmw_sequencer dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_opcode(instr_opcode),
        .instr_lo(instr_lo), .instr_hi(instr_hi), .instr_ready(instr_ready),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .acc(acc), .flag_c(flag_c), .flag_z(flag_z),
        .flag_n(flag_n), .done(done), .illegal(illegal)
    );

    // ALU model; the override lets the bench preload acc through an ASL A.
    logic       alu_force;
    logic [7:0] alu_force_val;
    assign alu_result = alu_force ? alu_force_val :
                        (alu_op == ALU_ASL) ? {alu_a[6:0], 1'b0} : 8'h00;

    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    int cyc = 0;
    int re_cnt = 0, we_cnt = 0, done_cnt = 0, re_cyc = 0, we_cyc = 0, bus_err = 0;
    logic [15:0] last_waddr;
    logic [7:0]  last_wdata;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (mem_re) begin re_cnt++; re_cyc = cyc; end
        if (mem_we) begin we_cnt++; we_cyc = cyc; last_waddr = mem_addr; last_wdata = mem_wdata; end
        if (done) done_cnt++;
        if (mem_re && mem_we) bus_err++;
        if (!mem_re && !mem_we && mem_addr != 16'h0000) bus_err++;
        if (!mem_we && mem_wdata != 8'h00) bus_err++;
        if (alu_b != 8'h00) bus_err++;
    end

    int ncmp = 0, nfail = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  op, lo, hi, init;
        logic        force_en;
        logic [7:0]  force_val;
        logic [7:0]  e_acc;
        logic        e_c, e_z, e_n, e_ill;
        int          e_lat;
        int          e_mem;
        logic [15:0] e_addr;
        logic [7:0]  e_wdata;
    } vec_t;

    vec_t vt [8];

    // Issue in the current (IDLE) cycle T; returns cycle offset of done (0 = never seen).
    task automatic issue(input logic [7:0] op, input logic [7:0] lo, input logic [7:0] hi,
                         input bit hold, output int lat, output logic ill_s, output int t0);
        t0 = cyc;
        instr_valid = 1'b1; instr_opcode = op; instr_lo = lo; instr_hi = hi;
        @(posedge clk); #1;
        if (!hold) instr_valid = 1'b0;
        lat = 0; ill_s = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (done) begin lat = k; ill_s = illegal; break; end
            if (hold) chk("ready low while busy", instr_ready, 1'b0);
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
    endtask

    initial begin
        int lat, t0, re0, we0, dn0;
        logic ill_s;

        rst = 1'b1; instr_valid = 1'b0; instr_opcode = 8'h00; instr_lo = 8'h00; instr_hi = 8'h00;
        alu_force = 1'b0; alu_force_val = 8'h00;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        vt[0] = '{8'h0A, 8'h00, 8'h00, 8'h00, 1'b1, 8'h81, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 2, 0, 16'h0000, 8'h00};
        vt[1] = '{8'h0A, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0, 16'h0000, 8'h00};
        vt[2] = '{8'h06, 8'h10, 8'h00, 8'h40, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 5, 1, 16'h0010, 8'h80};
        vt[3] = '{8'h0E, 8'h34, 8'h12, 8'h80, 1'b0, 8'h00, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 5, 1, 16'h1234, 8'h00};
        vt[4] = '{8'hEA, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h02, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 16'h0000, 8'h00};
        vt[5] = '{8'h06, 8'hFF, 8'hAB, 8'hC3, 1'b0, 8'h00, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 5, 1, 16'h00FF, 8'h86};
        vt[6] = '{8'h0A, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 16'h0000, 8'h00};
        vt[7] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 16'h0000, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        chk("rst alu_op", alu_op, ALU_NOP);
        chk("rst done", done, 1'b0);
        rst = 1'b0;
        #1;
        chk("reset ready", instr_ready, 1'b1);
        chk("reset acc", acc, 8'h00);
        chk("reset flags", {flag_c, flag_z, flag_n}, 3'b000);
        chk("reset strobes", {mem_re, mem_we, done, illegal}, 4'b0000);
        chk("reset alu_op", alu_op, ALU_NOP);

        for (int i = 0; i < 8; i++) begin
            if (vt[i].e_mem != 0) mem[vt[i].e_addr] = vt[i].init;
            alu_force = vt[i].force_en; alu_force_val = vt[i].force_val;
            re0 = re_cnt; we0 = we_cnt;
            chk($sformatf("v%0d ready", i), instr_ready, 1'b1);
            issue(vt[i].op, vt[i].lo, vt[i].hi, 1'b0, lat, ill_s, t0);
            alu_force = 1'b0;
            chk($sformatf("v%0d done latency", i), lat, vt[i].e_lat);
            chk($sformatf("v%0d illegal", i), ill_s, vt[i].e_ill);
            chk($sformatf("v%0d acc", i), acc, vt[i].e_acc);
            chk($sformatf("v%0d flags czn", i), {flag_c, flag_z, flag_n}, {vt[i].e_c, vt[i].e_z, vt[i].e_n});
            chk($sformatf("v%0d re count", i), re_cnt - re0, vt[i].e_mem);
            chk($sformatf("v%0d we count", i), we_cnt - we0, vt[i].e_mem);
            if (vt[i].e_mem != 0) begin
                chk($sformatf("v%0d re cycle", i), re_cyc - t0, 1);
                chk($sformatf("v%0d we cycle", i), we_cyc - t0, 4);
                chk($sformatf("v%0d write addr", i), last_waddr, vt[i].e_addr);
                chk($sformatf("v%0d write data", i), last_wdata, vt[i].e_wdata);
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d done one cycle", i), done, 1'b0);
        end

        // Reset during WAIT of an ASL zp.
        mem[16'h0020] = 8'h55;
        we0 = we_cnt; dn0 = done_cnt;
        instr_valid = 1'b1; instr_opcode = 8'h06; instr_lo = 8'h20; instr_hi = 8'h00;
        @(posedge clk); #1; instr_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("wait-rst idle", instr_ready, 1'b1);
        chk("wait-rst acc", acc, 8'h00);
        chk("wait-rst flags", {flag_c, flag_z, flag_n}, 3'b000);
        repeat (6) @(posedge clk);
        #1;
        chk("wait-rst no write", we_cnt - we0, 0);
        chk("wait-rst no done", done_cnt - dn0, 0);
        chk("wait-rst mem", mem[16'h0020], 8'h55);

        // Reset landing in the WRITE cycle must suppress the write.
        mem[16'h0021] = 8'h7F;
        we0 = we_cnt; dn0 = done_cnt;
        instr_valid = 1'b1; instr_opcode = 8'h06; instr_lo = 8'h21; instr_hi = 8'h00;
        @(posedge clk); #1; instr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("write cycle reached", mem_we, 1'b1);
        rst = 1'b1;
        #1;
        chk("write-rst we gated", mem_we, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("write-rst no write", we_cnt - we0, 0);
        chk("write-rst no done", done_cnt - dn0, 0);
        chk("write-rst mem", mem[16'h0021], 8'h7F);

        // instr_valid held through the busy cycles: exactly one acceptance.
        mem[16'h0030] = 8'h01;
        re0 = re_cnt; we0 = we_cnt;
        issue(8'h06, 8'h30, 8'h00, 1'b1, lat, ill_s, t0);
        chk("hold latency", lat, 5);
        @(posedge clk); #1;
        chk("hold back to idle", instr_ready, 1'b1);
        @(posedge clk); #1;
        chk("hold single read", re_cnt - re0, 1);
        chk("hold single write", we_cnt - we0, 1);
        chk("hold mem result", mem[16'h0030], 8'h02);

        // rst wins over a simultaneous instr_valid.
        dn0 = done_cnt;
        rst = 1'b1; instr_valid = 1'b1; instr_opcode = 8'h0A;
        @(posedge clk); #1;
        rst = 1'b0; instr_valid = 1'b0;
        chk("rst priority idle", instr_ready, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst priority no done", done_cnt - dn0, 0);

        chk("bus idle/overlap errors", bus_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
